// File: rtl/rf_writeback.sv
// Register-file writeback stage: merges ALU results and formatted load data
// into an in-order queue and drains one regfile write per cycle.
module rf_writeback #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        ld_valid,
  input  logic [4:0]  ld_rd,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_word,
  output logic        ld_ready,
  input  logic        flush,
  output logic        rf_write_en,
  output logic [4:0]  rf_write_reg,
  output logic [31:0] rf_write_data,
  output logic [31:0] pend_mask,
  output logic        busy
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

  wb_entry_t     mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, alu_idx_c;
  logic [CW-1:0] count_q, count_d, free_c;
  logic          en_q, en_d;
  logic [4:0]    reg_q, reg_d;
  logic [31:0]   data_q, data_d;
  logic          push_ld_c, push_alu_c, pop_c;
  logic [31:0]   ld_fmt_c;

  // Byte/halfword extraction and extension of the raw load word.
  function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] lo,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lo, 3'b000} +: 8];
    h = lo[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  fmt_load = {{24{b[7]}}, b};
      3'b100:  fmt_load = {24'h0, b};
      3'b001:  fmt_load = {{16{h[15]}}, h};
      3'b101:  fmt_load = {16'h0, h};
      default: fmt_load = w;
    endcase
  endfunction

  // Handshake: the ALU needs two free slots when a load may take one this cycle.
  always_comb begin
    free_c     = CW'(DEPTH) - count_q;
    ld_ready   = !flush && (free_c >= CW'(1));
    alu_ready  = !flush && ((free_c >= CW'(2)) || ((free_c >= CW'(1)) && !ld_valid));
    push_ld_c  = ld_valid && ld_ready && (ld_rd != 5'd0);
    push_alu_c = alu_valid && alu_ready && (alu_rd != 5'd0);
    pop_c      = (count_q != '0) && !flush;
    alu_idx_c  = wr_ptr_q + AW'(push_ld_c);
    ld_fmt_c   = fmt_load(ld_funct3, ld_addr_lo, ld_word);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    en_d     = 1'b0;
    reg_d    = reg_q;
    data_d   = data_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop_c) begin
        en_d     = 1'b1;
        reg_d    = mem_q[rd_ptr_q].rd;
        data_d   = mem_q[rd_ptr_q].data;
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      wr_ptr_d = wr_ptr_q + AW'(push_ld_c) + AW'(push_alu_c);
      count_d  = count_q + CW'(push_ld_c) + CW'(push_alu_c) - CW'(pop_c);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      en_q     <= 1'b0;
      reg_q    <= '0;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      en_q     <= en_d;
      reg_q    <= reg_d;
      data_q   <= data_d;
    end
  end

  // Storage needs no reset: slots are only read while counted as occupied.
  always_ff @(posedge clk) begin
    if (push_ld_c)  mem_q[wr_ptr_q]  <= '{rd: ld_rd, data: ld_fmt_c};
    if (push_alu_c) mem_q[alu_idx_c] <= '{rd: alu_rd, data: alu_data};
  end

  always_comb begin
    logic [AW-1:0] off;
    off       = '0;
    pend_mask = '0;
    if (en_q) pend_mask[reg_q] = 1'b1;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off = AW'(i) - rd_ptr_q;
      if (CW'(off) < count_q) pend_mask[mem_q[i].rd] = 1'b1;
    end
    busy = (count_q != '0) || en_q;
  end

  assign rf_write_en   = en_q;
  assign rf_write_reg  = reg_q;
  assign rf_write_data = data_q;

endmodule

// File: tb/tb_rf_writeback.sv
// Bench for rf_writeback: directed scenarios plus random traffic against a
// queue-based reference model of the writeback stage.
module tb_rf_writeback;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, ld_valid, flush;
  logic [4:0]  alu_rd, ld_rd;
  logic [31:0] alu_data, ld_word;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic        alu_ready, ld_ready, rf_write_en, busy;
  logic [4:0]  rf_write_reg;
  logic [31:0] rf_write_data, pend_mask;

  rf_writeback #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_funct3(ld_funct3), .ld_addr_lo(ld_addr_lo),
    .ld_word(ld_word), .ld_ready(ld_ready), .flush(flush),
    .rf_write_en(rf_write_en), .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
    .pend_mask(pend_mask), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  logic        m_en;
  logic [4:0]  m_reg;
  logic [31:0] m_data;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Load value from the ISA rules, using shifts and two's-complement arithmetic.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] lo,
                                           input logic [31:0] w);
    longint v;
    case (f3)
      3'b000, 3'b100: begin
        v = longint'((w >> (8 * int'(lo))) & 32'hFF);
        if (f3 == 3'b000 && v >= 128) v = v - 256;
      end
      3'b001, 3'b101: begin
        v = longint'((w >> (16 * int'(lo[1]))) & 32'hFFFF);
        if (f3 == 3'b001 && v >= 32768) v = v - 65536;
      end
      default: v = longint'(w);
    endcase
    return 32'(v);
  endfunction

  task automatic check_ready();
    int free;
    free = DEPTH - mq.size();
    chk("ld_ready", 32'(ld_ready), 32'(!flush && free >= 1));
    chk("alu_ready", 32'(alu_ready), 32'(!flush && (free >= 2 || (free >= 1 && !ld_valid))));
  endtask

  task automatic check_out();
    logic [31:0] pm;
    pm = '0;
    foreach (mq[i]) pm[mq[i].rd] = 1'b1;
    if (m_en) pm[m_reg] = 1'b1;
    chk("wr_en", 32'(rf_write_en), 32'(m_en));
    chk("wr_reg", 32'(rf_write_reg), 32'(m_reg));
    chk("wr_data", rf_write_data, m_data);
    chk("pend_mask", pend_mask, pm);
    chk("busy", 32'(busy), 32'(mq.size() > 0 || m_en));
  endtask

  task automatic drive(input logic lv, input logic [4:0] lrd, input logic [2:0] f3,
                       input logic [1:0] lo, input logic [31:0] lw,
                       input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic fl);
    ld_valid = lv; ld_rd = lrd; ld_funct3 = f3; ld_addr_lo = lo; ld_word = lw;
    alu_valid = av; alu_rd = ard; alu_data = ad; flush = fl;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 3'd0, 2'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  // One clock: check readiness, advance the model at the edge, check outputs.
  task automatic step();
    int   free;
    logic lacc, aacc;
    #1;
    check_ready();
    free = DEPTH - mq.size();
    lacc = ld_valid && !flush && free >= 1;
    aacc = alu_valid && !flush && (free >= 2 || (free >= 1 && !ld_valid));
    @(posedge clk);
    if (flush) begin
      mq.delete();
      m_en = 1'b0;
    end else begin
      if (mq.size() > 0) begin
        m_en = 1'b1; m_reg = mq[0].rd; m_data = mq[0].data;
        void'(mq.pop_front());
      end else begin
        m_en = 1'b0;
      end
      if (lacc && ld_rd != 5'd0) mq.push_back('{ld_rd, ref_load(ld_funct3, ld_addr_lo, ld_word)});
      if (aacc && alu_rd != 5'd0) mq.push_back('{alu_rd, alu_data});
    end
    @(negedge clk);
    check_out();
  endtask

  task automatic model_reset();
    mq.delete();
    m_en = 1'b0; m_reg = '0; m_data = '0;
  endtask

  task automatic fill_three();
    drive(1'b1, 5'd9, 3'b010, 2'd0, 32'h0000_0A0A, 1'b1, 5'd10, 32'h0000_0B0B, 1'b0);
    step();
    drive(1'b1, 5'd11, 3'b010, 2'd0, 32'h0000_0C0C, 1'b1, 5'd12, 32'h0000_0D0D, 1'b0);
    step();
  endtask

  initial begin
    rst = 1'b0;
    idle();
    model_reset();
    #2;
    check_out();
    ld_valid = 1'b1;
    #1;
    check_ready();
    idle();
    @(negedge clk);
    rst = 1'b1;

    // Scenario 1: lb from byte 3, sign-extended.
    drive(1'b1, 5'd5, 3'b000, 2'd3, 32'h8011_2233, 1'b0, 5'd0, 32'd0, 1'b0);
    step();
    idle();
    step();
    chk("s1_data", rf_write_data, 32'hFFFF_FF80);
    step();

    // Scenario 2: lhu upper halfword.
    drive(1'b1, 5'd7, 3'b101, 2'd2, 32'hBEEF_0000, 1'b0, 5'd0, 32'd0, 1'b0);
    step();
    idle();
    step();
    chk("s2_data", rf_write_data, 32'h0000_BEEF);
    step();

    // Scenario 3: simultaneous load and ALU offers; load goes first.
    drive(1'b1, 5'd3, 3'b010, 2'd0, 32'h11, 1'b1, 5'd4, 32'h22, 1'b0);
    step();
    chk("s3_pend", pend_mask, 32'h0000_0018);
    idle();
    step();
    chk("s3_first", 32'(rf_write_reg), 32'd3);
    step();
    chk("s3_second", 32'(rf_write_reg), 32'd4);
    step();

    // Scenario 4: six cycles of dual offers, forcing backpressure and wrap.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 5'($urandom_range(1, 31)), 3'($urandom_range(0, 7)), 2'($urandom),
            $urandom, 1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b0);
      step();
    end
    idle();
    for (int i = 0; i < 8; i++) step();

    // Scenario 5: ALU result to x0 is acknowledged but never written.
    drive(1'b0, 5'd0, 3'd0, 2'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0);
    step();
    idle();
    step();
    chk("s5_en", 32'(rf_write_en), 32'd0);
    chk("s5_pend", pend_mask, 32'd0);

    // Scenario 6a: flush with three queued entries.
    fill_three();
    drive(1'b1, 5'd13, 3'b010, 2'd0, 32'h1, 1'b1, 5'd14, 32'h2, 1'b1);
    step();
    chk("s6_flush_en", 32'(rf_write_en), 32'd0);
    chk("s6_flush_busy", 32'(busy), 32'd0);
    idle();
    step();

    // Scenario 6b: asynchronous reset in place of the flush.
    fill_three();
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_out();
    check_ready();
    @(posedge clk);
    @(negedge clk);
    check_out();
    rst = 1'b1;
    step();
    chk("s6_rst_en", 32'(rf_write_en), 32'd0);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom), 5'($urandom), 3'($urandom), 2'($urandom), $urandom,
            1'($urandom), 5'($urandom), $urandom, ($urandom_range(0, 19) == 0));
      step();
    end
    idle();
    for (int i = 0; i < 8; i++) step();
    chk("final_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_writeback.md
RF_WRITEBACK -- requirements
Module: rf_writeback

Interface
REQ-001 Parameter DEPTH, default 4, number of queued write entries; SHALL be a power of two, 2 to 16.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 alu_valid  input  1; alu_rd  input  5; alu_data  input  32: ALU result offer.
REQ-005 alu_ready  output  1: ALU offer accepted on a rising edge where alu_valid=1 and alu_ready=1.
REQ-006 ld_valid  input  1; ld_rd  input  5; ld_funct3  input  3; ld_addr_lo  input  2; ld_word  input  32: raw load response offer.
REQ-007 ld_ready  output  1: load offer accepted on a rising edge where ld_valid=1 and ld_ready=1.
REQ-008 flush  input  1: synchronous discard of all queued entries.
REQ-009 rf_write_en  output  1; rf_write_reg  output  5; rf_write_data  output  32: registered regfile write port.
REQ-010 pend_mask  output  32: bit r=1 iff a queued entry or the current output-stage entry targets rd=r.
REQ-011 busy  output  1: queue non-empty or rf_write_en=1.

Function
REQ-012 Load formatting, applied at acceptance:
- funct3 000 (lb): byte ld_word[8*addr_lo+:8], sign-extended.
- funct3 100 (lbu): same byte, zero-extended.
- funct3 001 (lh): halfword ld_word[16*addr_lo[1]+:16], sign-extended; addr_lo[0] ignored.
- funct3 101 (lhu): same halfword, zero-extended.
- funct3 010 and all other codes: ld_word unchanged.
REQ-013 Queue: FIFO of DEPTH entries {rd, data}; free = DEPTH - count, computed from registered state and not counting a same-cycle pop.
REQ-014 Readiness:
- ld_ready = !flush && free>=1.
- alu_ready = !flush && (free>=2, or free>=1 when ld_valid=0).
REQ-015 When both offers are accepted in one cycle, the load entry SHALL be pushed ahead of the ALU entry.
REQ-016 An accepted offer with rd=0 SHALL complete its handshake but SHALL NOT be pushed and SHALL NOT write.
REQ-017 Drain: on each rising edge with count>0 and flush=0, the head SHALL be popped into the output registers with rf_write_en=1; otherwise rf_write_en SHALL be 0.
REQ-018 rf_write_en SHALL be high for exactly one cycle per pushed entry, and entries SHALL be written in push order.
REQ-019 Latency: an entry accepted into an empty queue at edge N SHALL show rf_write_en=1 with its rd and data in the cycle after edge N+1.
REQ-020 Pops and pushes at the same edge are legal; count is updated by pushes minus pop, and the new count never exceeds DEPTH.
REQ-021 Pointers SHALL wrap modulo DEPTH with no lost or duplicated entries.
REQ-022 Flush: at an edge with flush=1, the queue SHALL be emptied and no push occurs.
- The following cycle shows rf_write_en=0.
- A write already in the output stage during the flush cycle SHALL complete unchanged.
REQ-023 rf_write_reg and rf_write_data SHALL hold their last values while rf_write_en=0.
REQ-024 pend_mask and busy SHALL be combinational from registered state only.

Reset
REQ-025 While rst=0:
- queue empty, pointers 0;
- rf_write_en=0, rf_write_reg=0, rf_write_data=0;
- pend_mask=0, busy=0.
REQ-026 While rst=0, alu_ready and ld_ready SHALL follow REQ-014 with an empty queue, so both are 1 when flush=0.
REQ-027 Reset asserted mid-operation SHALL discard all queued and output-stage entries immediately, with no rf_write_en pulse afterward.

Verification
REQ-028 Scenario 1: ld_funct3=000, addr_lo=3, ld_word=0x80112233, ld_rd=5 -> one cycle of rf_write_en=1, rf_write_reg=5, rf_write_data=0xFFFFFF80.
REQ-029 Scenario 2: ld_funct3=101, addr_lo=2, ld_word=0xBEEF0000, ld_rd=7 -> rf_write_data=0x0000BEEF, written in the cycle after edge N+1 per REQ-019.
REQ-030 Scenario 3: load (rd=3, lw 0x11) and ALU (rd=4, 0x22) offered in the same cycle on an empty queue:
- both accepted;
- writes rd=3 then rd=4 on consecutive cycles;
- pend_mask bits 3 and 4 set until each is written.
REQ-031 Scenario 4: offers for 6 consecutive cycles with both sources valid, DEPTH=4 ->
- alu_ready drops once free<2;
- FIFO wraps;
- all accepted entries written exactly once, in order.
REQ-032 Scenario 5: ALU offer rd=0, data 0xDEADBEEF -> alu_ready handshake completes; rf_write_en stays 0; pend_mask stays 0.
REQ-033 Scenario 6: queue holding 3 entries, flush=1 for one cycle ->
- at most the output-stage write completes;
- then rf_write_en=0, busy=0, pend_mask=0.
- Repeating the test with rst=0 pulsed instead of flush SHALL show the same result with no write at all.
